// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the execution-unit writeback arbiter.
//   - Default parameter values used by exe_wb_arbiter.
//   - wb_entry_t: the {rd, data} layout of one buffered result at the default
//     widths. Parameterised instances build the same layout with their own
//     widths (rd in the upper bits, data in the lower bits).
//   - idx_w(): index width helper that never returns 0.
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_N_CH_DEF    = 4;
  localparam int WB_DATA_W_DEF  = 32;
  localparam int WB_RD_W_DEF    = 4;
  localparam int WB_DEPTH_DEF   = 2;
  localparam int WB_RR_MODE_DEF = 0;

  typedef struct packed {
    logic [WB_RD_W_DEF-1:0]   rd;
    logic [WB_DATA_W_DEF-1:0] data;
  } wb_entry_t;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Per-channel result buffer of DEPTH entries, W bits each (DEPTH power of 2).
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (empties the buffer)
//   push_i   in   write din_i at the tail (ignored when full)
//   din_i    in   W-bit entry to write
//   pop_i    in   drop the head entry (ignored when empty)
//   head_o   out  oldest entry; only meaningful while count_o != 0
//   count_o  out  registered number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W-1:0]     din_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // A full buffer refuses a push even when the head leaves on the same edge;
  // the freed slot becomes visible one cycle later.
  assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty buffer never exposes its contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/exe_wb_arbiter.sv
// -----------------------------------------------------------------------------
// exe_wb_arbiter
// Collects results from N_CH execution-unit channels into per-channel buffers
// and writes back one result per cycle to the register file.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   [N_CH]          channel i offers a result
//   in_ready   out  [N_CH]          channel i buffer has space (registered)
//   in_rd      in   [N_CH*RD_W]     destination register, channel i at slice i
//   in_data    in   [N_CH*DATA_W]   result value, channel i at slice i
//   wb_valid   out                  register-file write enable (registered)
//   wb_rd      out  [RD_W]          write destination (registered)
//   wb_data    out  [DATA_W]        write data (registered)
//   wb_ch      out  [clog2(N_CH)]   channel that produced the write
//   occupancy  out  [N_CH*clog2(DEPTH+1)]  per-channel entry count
// RR_MODE = 0 grants the lowest-index non-empty channel; RR_MODE = 1 searches
// from a rotating pointer that moves just past each granted channel.
// -----------------------------------------------------------------------------
module exe_wb_arbiter
  import wb_pkg::*;
#(
  parameter int N_CH    = WB_N_CH_DEF,
  parameter int DATA_W  = WB_DATA_W_DEF,
  parameter int RD_W    = WB_RD_W_DEF,
  parameter int DEPTH   = WB_DEPTH_DEF,
  parameter int RR_MODE = WB_RR_MODE_DEF,
  localparam int CH_W  = idx_w(N_CH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [N_CH*RD_W-1:0]   in_rd,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic                   wb_valid,
  output logic [RD_W-1:0]        wb_rd,
  output logic [DATA_W-1:0]      wb_data,
  output logic [CH_W-1:0]        wb_ch,
  output logic [N_CH*CNT_W-1:0]  occupancy
);

  localparam int ENT_W = RD_W + DATA_W;

  // Same field order as wb_pkg::wb_entry_t, sized by this instance.
  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           head   [N_CH];
  logic [CNT_W-1:0] count  [N_CH];
  logic [N_CH-1:0]  nonempty;
  logic [N_CH-1:0]  pop;

  logic             grant_vld;
  logic [CH_W-1:0]  grant_idx;
  entry_t           grant_head;

  logic             wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]  wb_rd_q,    wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [CH_W-1:0]  wb_ch_q,    wb_ch_d;
  logic [CH_W-1:0]  rr_ptr_q,   rr_ptr_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    entry_t din;

    assign din.rd   = in_rd[i*RD_W +: RD_W];
    assign din.data = in_data[i*DATA_W +: DATA_W];

    // Ready depends only on the registered count, never on valid or grant.
    assign in_ready[i] = (count[i] != CNT_W'(DEPTH));
    assign nonempty[i] = (count[i] != '0);
    assign occupancy[i*CNT_W +: CNT_W] = count[i];

    wb_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (in_valid[i] & in_ready[i]),
      .din_i   (din),
      .pop_i   (pop[i]),
      .head_o  (head[i]),
      .count_o (count[i])
    );
  end

  // Priority search. In round-robin mode the scan starts at rr_ptr_q and
  // wraps; in fixed mode it always starts at channel 0.
  always_comb begin
    int c;
    c         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      c = (RR_MODE != 0) ? ((int'(rr_ptr_q) + k) % N_CH) : k;
      if (!grant_vld && nonempty[c]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'(c);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant_vld) pop[grant_idx] = 1'b1;
  end

  assign grant_head = head[grant_idx];

  // Without a grant the data fields hold so the register file sees stable
  // values; only the enable drops.
  always_comb begin
    wb_valid_d = grant_vld;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_ch_d    = wb_ch_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_vld) begin
      wb_rd_d   = grant_head.rd;
      wb_data_d = grant_head.data;
      wb_ch_d   = grant_idx;
      rr_ptr_d  = CH_W'((int'(grant_idx) + 1) % N_CH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_ch_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_ch_q    <= wb_ch_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_ch    = wb_ch_q;

endmodule

// File: tb/tb_exe_wb_arbiter.sv
module tb_exe_wb_arbiter;

  localparam int N_CH   = 4;
  localparam int DATA_W = 32;
  localparam int RD_W   = 4;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 2;
  localparam int CH_W   = 2;
  localparam int N_DUT  = 2;   // instance 0: fixed priority, instance 1: round-robin

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N_CH-1:0]        in_valid = '0;
  logic [N_CH*RD_W-1:0]   in_rd    = '0;
  logic [N_CH*DATA_W-1:0] in_data  = '0;

  logic [N_CH-1:0]       rdy    [N_DUT];
  logic                  wbv    [N_DUT];
  logic [RD_W-1:0]       wbrd   [N_DUT];
  logic [DATA_W-1:0]     wbdata [N_DUT];
  logic [CH_W-1:0]       wbch   [N_DUT];
  logic [N_CH*CNT_W-1:0] occ    [N_DUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    exe_wb_arbiter #(
      .N_CH    (N_CH),
      .DATA_W  (DATA_W),
      .RD_W    (RD_W),
      .DEPTH   (DEPTH),
      .RR_MODE (g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .in_rd     (in_rd),
      .in_data   (in_data),
      .wb_valid  (wbv[g]),
      .wb_rd     (wbrd[g]),
      .wb_data   (wbdata[g]),
      .wb_ch     (wbch[g]),
      .occupancy (occ[g])
    );
  end

  typedef struct {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    int                ch;
  } wb_t;

  // Reference model: one queue per (instance, channel), scoreboard per instance.
  wb_t mq  [N_DUT*N_CH][$];
  wb_t sbq [N_DUT][$];
  bit  exp_v [N_DUT];
  int  rr    [N_DUT];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Model step: grant from the queues as they stood before the edge, then
  // accept every offered result whose queue had room before the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < N_DUT; m++) begin
        for (int c = 0; c < N_CH; c++) mq[m*N_CH+c].delete();
        sbq[m].delete();
        exp_v[m] = 1'b0;
        rr[m]    = 0;
      end
    end else begin
      for (int m = 0; m < N_DUT; m++) begin
        int  g;
        int  c;
        bit  acc [N_CH];
        wb_t e;
        g = -1;
        for (int k = 0; k < N_CH; k++) begin
          c = (m == 1) ? (rr[m] + k) % N_CH : k;
          if (g < 0 && mq[m*N_CH+c].size() > 0) g = c;
        end
        for (int k = 0; k < N_CH; k++)
          acc[k] = in_valid[k] && (mq[m*N_CH+k].size() < DEPTH);
        if (g >= 0) begin
          e = mq[m*N_CH+g].pop_front();
          sbq[m].push_back(e);
          exp_v[m] = 1'b1;
          rr[m]    = (g + 1) % N_CH;
        end else begin
          exp_v[m] = 1'b0;
        end
        for (int k = 0; k < N_CH; k++) begin
          if (acc[k]) begin
            e.rd   = in_rd[k*RD_W +: RD_W];
            e.data = in_data[k*DATA_W +: DATA_W];
            e.ch   = k;
            mq[m*N_CH+k].push_back(e);
          end
        end
      end
    end
  end

  // Monitor: every cycle compare enable, occupancy and ready; on a writeback
  // pop the scoreboard and compare the payload.
  always @(negedge clk) begin
    for (int m = 0; m < N_DUT; m++) begin
      wb_t e;
      chk($sformatf("d%0d_wb_valid", m), 64'(wbv[m]), 64'(exp_v[m]));
      if (exp_v[m] && sbq[m].size() > 0) begin
        e = sbq[m].pop_front();
        if (wbv[m]) begin
          chk($sformatf("d%0d_wb_rd", m),   64'(wbrd[m]),   64'(e.rd));
          chk($sformatf("d%0d_wb_data", m), 64'(wbdata[m]), 64'(e.data));
          chk($sformatf("d%0d_wb_ch", m),   64'(wbch[m]),   64'(e.ch));
        end
      end
      for (int c = 0; c < N_CH; c++) begin
        chk($sformatf("d%0d_occ%0d", m, c), 64'(occ[m][c*CNT_W +: CNT_W]),
            64'(mq[m*N_CH+c].size()));
        chk($sformatf("d%0d_ready%0d", m, c), 64'(rdy[m][c]),
            64'(mq[m*N_CH+c].size() < DEPTH));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ch(input int c, input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] d);
    in_valid[c] = 1'b1;
    in_rd[c*RD_W +: RD_W] = rd;
    in_data[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    in_valid = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    for (int m = 0; m < N_DUT; m++) begin
      chk($sformatf("rst_d%0d_wb_valid", m), 64'(wbv[m]), 64'd0);
      chk($sformatf("rst_d%0d_wb_rd", m), 64'(wbrd[m]), 64'd0);
      chk($sformatf("rst_d%0d_wb_data", m), 64'(wbdata[m]), 64'd0);
      chk($sformatf("rst_d%0d_wb_ch", m), 64'(wbch[m]), 64'd0);
      chk($sformatf("rst_d%0d_occ", m), 64'(occ[m]), 64'd0);
      chk($sformatf("rst_d%0d_ready", m), 64'(rdy[m]), 64'hF);
    end
    cyc();
    rst = 1'b0;

    // Single result on ch2, pushed at the first edge after reset release.
    set_ch(2, 4'd5, 32'hDEADBEEF);
    cyc();
    in_valid = '0;
    for (int m = 0; m < N_DUT; m++)
      chk($sformatf("one_d%0d_not_yet", m), 64'(wbv[m]), 64'd0);
    cyc();
    for (int m = 0; m < N_DUT; m++) begin
      chk($sformatf("one_d%0d_valid", m), 64'(wbv[m]), 64'd1);
      chk($sformatf("one_d%0d_rd", m), 64'(wbrd[m]), 64'd5);
      chk($sformatf("one_d%0d_data", m), 64'(wbdata[m]), 64'hDEADBEEF);
      chk($sformatf("one_d%0d_ch", m), 64'(wbch[m]), 64'd2);
    end
    cyc();
    for (int m = 0; m < N_DUT; m++)
      chk($sformatf("one_d%0d_drop", m), 64'(wbv[m]), 64'd0);

    // All four channels at once, fixed priority drains 0,1,2,3.
    for (int c = 0; c < N_CH; c++) set_ch(c, 4'(c + 1), 32'h100 + c);
    cyc();
    in_valid = '0;
    for (int k = 0; k < N_CH; k++) begin
      cyc();
      chk("fixed_order_valid", 64'(wbv[0]), 64'd1);
      chk("fixed_order_ch", 64'(wbch[0]), 64'(k));
    end
    cyc();

    // Two entries per channel, round-robin: 0,1,2,3,0,1,2,3 back to back.
    do_reset();
    for (int c = 0; c < N_CH; c++) set_ch(c, 4'(c), 32'h200 + c);
    cyc();
    for (int c = 0; c < N_CH; c++) set_ch(c, 4'(c + 8), 32'h210 + c);
    cyc();
    in_valid = '0;
    for (int k = 0; k < 8; k++) begin
      chk("rr_burst_valid", 64'(wbv[1]), 64'd1);
      chk("rr_order_ch", 64'(wbch[1]), 64'(k % N_CH));
      chk("fixed_burst_valid", 64'(wbv[0]), 64'd1);
      cyc();
    end
    chk("rr_burst_end", 64'(wbv[1]), 64'd0);
    chk("fixed_burst_end", 64'(wbv[0]), 64'd0);

    // ch0 streams continuously; fixed priority starves ch1 until ch0 stops.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_ch(0, 4'(i), 32'h3000 + i);
      set_ch(1, 4'(i), 32'h4000 + i);
      cyc();
    end
    chk("starve_ready1", 64'(rdy[0][1]), 64'd0);
    chk("starve_occ1", 64'(occ[0][CNT_W +: CNT_W]), 64'd2);
    chk("starve_occ0", 64'(occ[0][0 +: CNT_W]), 64'd1);
    in_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ch(1, 4'(i + 8), 32'h4100 + i);
      cyc();
    end
    in_valid = '0;
    repeat (6) cyc();

    // Steady push+pop on a single-entry channel keeps occupancy at 1.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      set_ch(3, 4'(i), 32'h5000 + i);
      cyc();
      for (int m = 0; m < N_DUT; m++)
        chk($sformatf("steady_d%0d_occ3", m), 64'(occ[m][3*CNT_W +: CNT_W]), 64'd1);
    end
    in_valid = '0;
    repeat (3) cyc();

    // Reset mid-operation with three busy channels.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 1; c < N_CH; c++) set_ch(c, 4'(c), 32'h6000 + 16 * i + c);
      cyc();
    end
    in_valid = '0;
    rst = 1'b1;
    #1;
    for (int m = 0; m < N_DUT; m++) begin
      chk($sformatf("midrst_d%0d_occ", m), 64'(occ[m]), 64'd0);
      chk($sformatf("midrst_d%0d_valid", m), 64'(wbv[m]), 64'd0);
      chk($sformatf("midrst_d%0d_ready", m), 64'(rdy[m]), 64'hF);
    end
    cyc();
    rst = 1'b0;
    repeat (3) begin
      cyc();
      for (int m = 0; m < N_DUT; m++)
        chk($sformatf("midrst_d%0d_stale", m), 64'(wbv[m]), 64'd0);
    end

    // Random traffic with load varying between phases.
    for (int ph = 0; ph < 16; ph++) begin
      int load;
      load = $urandom_range(1, 4);
      for (int i = 0; i < 100; i++) begin
        for (int c = 0; c < N_CH; c++) begin
          in_valid[c] = ($urandom_range(0, 3) < load);
          in_rd[c*RD_W +: RD_W] = 4'($urandom);
          in_data[c*DATA_W +: DATA_W] = $urandom;
        end
        cyc();
      end
    end
    in_valid = '0;
    repeat (20) cyc();
    for (int m = 0; m < N_DUT; m++)
      chk($sformatf("d%0d_leftover", m), 64'(sbq[m].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
